acc_core: RTL



---
 rtl/acc_core.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/acc_core.sv
// acc_core: multi-cycle accumulator CPU (FETCH/DECODE/EXEC/MEMRD/IOWAIT/HALT).
// Define ACC_CORE_INSTRET_EN to add the 32-bit retired-instruction counter port instret_o.
module acc_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    output logic [ADDR_W-1:0]   ins_addr_o,
    input  logic [ADDR_W+3:0]   ins_data_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_re_o,
    output logic                mem_we_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic [DATA_W-1:0]   inp_data_i,
    input  logic                inp_valid_i,
    output logic                inp_ready_o,
    output logic [DATA_W-1:0]   out_data_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [ADDR_W-1:0]   pc_o,
    output logic [DATA_W-1:0]   acc_o,
    output logic [1:0]          flags_o,
    output logic                halted_o
`ifdef ACC_CORE_INSTRET_EN
    ,
    output logic [31:0]         instret_o
`endif
);

    localparam int IW = ADDR_W + 4;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEMRD,
        S_IOWAIT,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_ADDI = 4'h9,
        OP_JMP  = 4'hA,
        OP_JZ   = 4'hB,
        OP_JC   = 4'hC,
        OP_IN   = 4'hD,
        OP_OUT  = 4'hE,
        OP_HLT  = 4'hF
    } opcode_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IW-1:0]       r_ir;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_acc;
    logic                r_c;
    logic                r_z;

    opcode_t             w_op;
    logic [ADDR_W-1:0]   w_operand;
    logic [DATA_W-1:0]   w_imm;
    logic [DATA_W-1:0]   w_b;
    logic                w_mem_op;
    logic                w_in_fire;
    logic                w_out_fire;

    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_alu_c;
    logic                w_alu_z;

    assign w_op      = opcode_t'(r_ir[IW-1 -: 4]);
    assign w_operand = r_ir[ADDR_W-1:0];
    assign w_imm     = w_operand[DATA_W-1:0];
    // Only ADDI takes its second operand from the instruction; the rest use the memory read data.
    assign w_b       = (w_op == OP_ADDI) ? w_imm : mem_rdata_i;
    assign w_mem_op  = (w_op == OP_LD)  || (w_op == OP_ADD) || (w_op == OP_SUB) ||
                       (w_op == OP_AND) || (w_op == OP_OR)  || (w_op == OP_XOR);

    // Strobes decode purely from state and ir, so an asynchronous reset drops them at once.
    assign ins_addr_o  = r_pc;
    assign mem_addr_o  = w_operand;
    assign mem_wdata_o = r_acc;
    assign mem_re_o    = (r_state == S_EXEC) && w_mem_op;
    assign mem_we_o    = (r_state == S_EXEC) && (w_op == OP_ST);
    assign inp_ready_o = (r_state == S_IOWAIT) && (w_op == OP_IN);
    assign out_valid_o = (r_state == S_IOWAIT) && (w_op == OP_OUT);
    assign out_data_o  = r_acc;
    assign pc_o        = r_pc;
    assign acc_o       = r_acc;
    assign flags_o     = {r_c, r_z};
    assign halted_o    = (r_state == S_HALT);

    assign w_in_fire   = inp_valid_i && inp_ready_o;
    assign w_out_fire  = out_valid_o && out_ready_i;

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path can infer a latch.
        w_sum     = '0;
        w_alu_res = r_acc;
        w_alu_c   = r_c;
        case (w_op)
            OP_LD: begin
                w_alu_res = w_b;
            end
            OP_ADD, OP_ADDI: begin
                w_sum     = {1'b0, r_acc} + {1'b0, w_b};
                w_alu_res = w_sum[DATA_W-1:0];
                w_alu_c   = w_sum[DATA_W];
            end
            OP_SUB: begin
                w_alu_res = r_acc - w_b;
                w_alu_c   = (r_acc >= w_b);
            end
            OP_AND: begin
                w_alu_res = r_acc & w_b;
                w_alu_c   = 1'b0;
            end
            OP_OR: begin
                w_alu_res = r_acc | w_b;
                w_alu_c   = 1'b0;
            end
            OP_XOR: begin
                w_alu_res = r_acc ^ w_b;
                w_alu_c   = 1'b0;
            end
            default: ;
        endcase
        w_alu_z = (w_alu_res == '0);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH:  w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = S_EXEC;
            S_EXEC: begin
                if (w_mem_op) begin
                    w_state_nxt = S_MEMRD;
                end else if ((w_op == OP_IN) || (w_op == OP_OUT)) begin
                    w_state_nxt = S_IOWAIT;
                end else if (w_op == OP_HLT) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_MEMRD:  w_state_nxt = S_FETCH;
            S_IOWAIT: begin
                if (w_in_fire || w_out_fire) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
            r_pc    <= '0;
            r_acc   <= '0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_DECODE: begin
                    r_ir <= ins_data_i;
                    r_pc <= r_pc + ADDR_W'(1);
                end
                S_EXEC: begin
                    case (w_op)
                        OP_LDI: r_acc <= w_imm;
                        OP_ADDI: begin
                            r_acc <= w_alu_res;
                            r_c   <= w_alu_c;
                            r_z   <= w_alu_z;
                        end
                        OP_JMP: r_pc <= w_operand;
                        OP_JZ: begin
                            if (r_z) r_pc <= w_operand;
                        end
                        OP_JC: begin
                            if (r_c) r_pc <= w_operand;
                        end
                        default: ;
                    endcase
                end
                S_MEMRD: begin
                    r_acc <= w_alu_res;
                    if (w_op != OP_LD) begin
                        r_c <= w_alu_c;
                        r_z <= w_alu_z;
                    end
                end
                S_IOWAIT: begin
                    if (w_in_fire) r_acc <= inp_data_i;
                end
                default: ;
            endcase
        end
    end

`ifdef ACC_CORE_INSTRET_EN
    logic        w_retire;
    logic [31:0] r_instret;

    // An instruction retires when it leaves a completing state for FETCH or HALT.
    assign w_retire = ((r_state == S_EXEC) || (r_state == S_MEMRD) || (r_state == S_IOWAIT)) &&
                      ((w_state_nxt == S_FETCH) || (w_state_nxt == S_HALT));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign instret_o = r_instret;
`endif

endmodule
